// File: rtl/meas_sequencer_if.sv
// Command/event/strobe bundle between the measurement sequencer and its host logic.
// slave = sequencer side, master = host side driving commands and converter events.
interface meas_sequencer_if #(
    parameter int Width    = 8,
    parameter int NumCh    = 4,
    parameter int CntWidth = 16
);
    localparam int ChW = (NumCh > 1) ? $clog2(NumCh) : 1;

    logic [Width-1:0]    cmd_i;
    logic                cmd_valid_i;
    logic                eot_i;
    logic                eoramp_i;
    logic                eosar_i;
    logic                tick_start_i;
    logic                tick_sample_i;

    logic                start_tx_o;
    logic                start_ramp_o;
    logic                start_sar_o;
    logic [ChW-1:0]      ch_sel_o;
    logic [CntWidth-1:0] sample_cnt_o;
    logic                busy_o;
    logic                done_o;
    logic                err_o;

    // cmd_valid_i is a one-cycle qualifier for cmd_i; events and strobes are
    // single-cycle pulses with no ready/backpressure (eoramp_i is a level).
    modport slave (
        input  cmd_i, cmd_valid_i, eot_i, eoramp_i, eosar_i, tick_start_i, tick_sample_i,
        output start_tx_o, start_ramp_o, start_sar_o, ch_sel_o, sample_cnt_o,
               busy_o, done_o, err_o
    );

    modport master (
        output cmd_i, cmd_valid_i, eot_i, eoramp_i, eosar_i, tick_start_i, tick_sample_i,
        input  start_tx_o, start_ramp_o, start_sar_o, ch_sel_o, sample_cnt_o,
               busy_o, done_o, err_o
    );
endinterface

// File: rtl/meas_sequencer.sv
// Measurement sequencer: runs ramp (single channel) or scan (NumCh channels) sweeps,
// pacing SAR conversions and UART transmissions off sync/sample ticks.
module meas_sequencer #(
    parameter int               Width         = 8,
    parameter int               NumCh         = 4,
    parameter int               CntWidth      = 16,
    parameter int               TimeoutCycles = 1000000,
    parameter logic [Width-1:0] CmdRamp       = 8'h01,
    parameter logic [Width-1:0] CmdScan       = 8'h02,
    parameter logic [Width-1:0] CmdAbort      = 8'h03
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    meas_sequencer_if.slave     io_bus,
    output logic [2:0]          o_dbg_state
);
    localparam int                ChW     = (NumCh > 1) ? $clog2(NumCh) : 1;
    localparam int                TmoW    = $clog2(TimeoutCycles + 1);
    localparam logic [TmoW-1:0]   TmoLast = TmoW'(TimeoutCycles - 2);
    localparam logic [ChW-1:0]    ChLast  = ChW'(NumCh - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_SYNC   = 3'd2,
        S_CONV   = 3'd3,
        S_TX     = 3'd4,
        S_NEXT   = 3'd5,
        S_END1   = 3'd6,
        S_END2   = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_mode;
    logic [Width-1:0]    r_cmd;
    logic [TmoW-1:0]     r_tmo_cnt;
    logic [ChW-1:0]      r_ch_sel;
    logic [CntWidth-1:0] r_sample_cnt;
    logic                r_err;

    logic w_abort;
    logic w_timeout;
    logic w_ld_cmd;
    logic w_clear;
    logic w_set_err;
    logic w_ch_inc;
    logic w_pt_done;
    logic w_start_tx;
    logic w_start_ramp;
    logic w_start_sar;
    logic w_done;

    assign w_abort   = io_bus.cmd_valid_i && (io_bus.cmd_i == CmdAbort) &&
                       (r_state inside {S_SYNC, S_CONV, S_TX, S_NEXT, S_END1, S_END2});
    // The counter value TmoLast is seen in the cycle that would make TimeoutCycles-1.
    assign w_timeout = (r_state inside {S_CONV, S_TX}) && (r_tmo_cnt == TmoLast);
    assign w_ld_cmd  = (r_state == S_IDLE) && io_bus.cmd_valid_i;

    always_comb begin
        w_state_nxt  = r_state;
        w_clear      = 1'b0;
        w_set_err    = 1'b0;
        w_ch_inc     = 1'b0;
        w_pt_done    = 1'b0;
        w_start_tx   = 1'b0;
        w_start_ramp = 1'b0;
        w_start_sar  = 1'b0;
        w_done       = 1'b0;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_set_err   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.cmd_valid_i) w_state_nxt = S_DECODE;
                end
                S_DECODE: begin
                    if (r_cmd == CmdRamp || r_cmd == CmdScan) begin
                        w_start_ramp = 1'b1;
                        w_clear      = 1'b1;
                        w_state_nxt  = S_SYNC;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_SYNC: begin
                    if (io_bus.tick_start_i) begin
                        w_start_sar = 1'b1;
                        w_state_nxt = S_CONV;
                    end
                end
                S_CONV: begin
                    if (io_bus.eosar_i) begin
                        w_start_tx  = 1'b1;
                        w_state_nxt = S_TX;
                    end
                end
                S_TX: begin
                    if (io_bus.eot_i) begin
                        if (r_mode && (r_ch_sel < ChLast)) begin
                            w_ch_inc    = 1'b1;
                            w_start_sar = 1'b1;
                            w_state_nxt = S_CONV;
                        end else begin
                            w_pt_done   = 1'b1;
                            w_state_nxt = io_bus.eoramp_i ? S_END1 : S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    if (io_bus.tick_sample_i) begin
                        w_start_sar = 1'b1;
                        w_state_nxt = S_CONV;
                    end
                end
                S_END1: w_state_nxt = S_END2;
                S_END2: begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mode       <= 1'b0;
            r_cmd        <= '0;
            r_tmo_cnt    <= '0;
            r_ch_sel     <= '0;
            r_sample_cnt <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_ld_cmd) r_cmd <= io_bus.cmd_i;
            // Any state change, including TX->CONV between channels, restarts the wait.
            if ((r_state inside {S_CONV, S_TX}) && (w_state_nxt == r_state)) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
            if (w_clear) begin
                r_mode       <= (r_cmd == CmdScan);
                r_ch_sel     <= '0;
                r_sample_cnt <= '0;
                r_err        <= 1'b0;
            end else begin
                if (w_set_err) r_err <= 1'b1;
                if (w_ch_inc) begin
                    r_ch_sel <= r_ch_sel + 1'b1;
                end else if (w_pt_done) begin
                    r_ch_sel <= '0;
                end
                if (w_pt_done && (r_sample_cnt != '1)) r_sample_cnt <= r_sample_cnt + 1'b1;
            end
        end
    end

    assign io_bus.start_tx_o   = w_start_tx;
    assign io_bus.start_ramp_o = w_start_ramp;
    assign io_bus.start_sar_o  = w_start_sar;
    assign io_bus.done_o       = w_done;
    assign io_bus.ch_sel_o     = r_ch_sel;
    assign io_bus.sample_cnt_o = r_sample_cnt;
    assign io_bus.err_o        = r_err;
    assign io_bus.busy_o       = (r_state != S_IDLE);
    assign o_dbg_state         = r_state;
endmodule

// File: tb/tb_meas_sequencer.sv
// Self-checking bench for meas_sequencer: strobe scoreboard plus per-scenario checks.
module tb_meas_sequencer;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_DECODE = 3'd1, ST_SYNC = 3'd2, ST_CONV = 3'd3;
    localparam logic [2:0] ST_TX = 3'd4, ST_NEXT = 3'd5, ST_END1 = 3'd6, ST_END2 = 3'd7;
    localparam logic [3:0] EV_TX = 4'b1000, EV_RAMP = 4'b0100, EV_SAR = 4'b0010, EV_DONE = 4'b0001;
    localparam int SIG_EOSAR = 0, SIG_EOT = 1, SIG_TSTART = 2, SIG_TSAMPLE = 3;

    logic       clk;
    logic       rst_n;
    logic [2:0] dbg_state;
    int         checks;
    int         errors;
    logic [5:0] exp_q[$];

    meas_sequencer_if #(.Width(8), .NumCh(4), .CntWidth(16)) bus ();

    meas_sequencer #(
        .Width(8), .NumCh(4), .CntWidth(16), .TimeoutCycles(16),
        .CmdRamp(8'h01), .CmdScan(8'h02), .CmdAbort(8'h03)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .io_bus      (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    // Strobe word = {tx, ramp, sar, done, ch}; ch is only meaningful for tx/done.
    always @(negedge clk) begin
        logic [5:0] act;
        logic [5:0] e;
        if (rst_n && (bus.start_tx_o || bus.start_ramp_o || bus.start_sar_o || bus.done_o)) begin
            act = {bus.start_tx_o, bus.start_ramp_o, bus.start_sar_o, bus.done_o,
                   (bus.start_tx_o || bus.done_o) ? bus.ch_sel_o : 2'd0};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: got %b required none at %0t", act, $time);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL pulse_seq: got %b required %b at %0t", act, e, $time);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic void expect_ev(input logic [3:0] k, input logic [1:0] ch);
        exp_q.push_back({k, ch});
    endfunction

    task automatic set_sig(input int sig, input logic v);
        case (sig)
            SIG_EOSAR:   bus.eosar_i       = v;
            SIG_EOT:     bus.eot_i         = v;
            SIG_TSTART:  bus.tick_start_i  = v;
            default:     bus.tick_sample_i = v;
        endcase
    endtask

    task automatic wait_state(input logic [2:0] st, input string nm);
        int n;
        n = 0;
        while (dbg_state !== st && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dbg_state !== st) begin
            errors++;
            $display("FAIL wait_%s: state=%0d required %0d", nm, dbg_state, st);
        end
    endtask

    task automatic send_cmd(input logic [7:0] c);
        @(posedge clk); #1;
        bus.cmd_i       = c;
        bus.cmd_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic ev(input int sig, input logic [2:0] st);
        wait_state(st, "ev");
        @(posedge clk); #1;
        set_sig(sig, 1'b1);
        @(posedge clk); #1;
        set_sig(sig, 1'b0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.cmd_i = 8'h01; bus.cmd_valid_i = 1'b1; bus.tick_start_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy_o, bus.done_o, bus.err_o, bus.start_tx_o, bus.start_ramp_o,
             bus.start_sar_o, bus.ch_sel_o, bus.sample_cnt_o} !== 24'd0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_outputs: state=%0d busy=%b err=%b cnt=%0d required all 0",
                     dbg_state, bus.busy_o, bus.err_o, bus.sample_cnt_o);
        end
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0; bus.tick_start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (dbg_state !== ST_IDLE || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_exit: state=%0d busy=%b required 0/0", dbg_state, bus.busy_o);
        end
    endtask

    task automatic test_ramp();
        int lat;
        lat = 0;
        wait_state(ST_IDLE, "ramp_idle");
        bus.eoramp_i = 1'b0;
        expect_ev(EV_RAMP, 2'd0); send_cmd(8'h01);
        expect_ev(EV_SAR, 2'd0);  ev(SIG_TSTART, ST_SYNC);
        expect_ev(EV_TX, 2'd0);   ev(SIG_EOSAR, ST_CONV);
        ev(SIG_EOT, ST_TX);
        checks++;
        if (dbg_state !== ST_NEXT || bus.sample_cnt_o !== 16'd1 || bus.ch_sel_o !== 2'd0) begin
            errors++;
            $display("FAIL ramp_point1: state=%0d cnt=%0d ch=%0d required 5/1/0",
                     dbg_state, bus.sample_cnt_o, bus.ch_sel_o);
        end
        expect_ev(EV_SAR, 2'd0);  ev(SIG_TSAMPLE, ST_NEXT);
        expect_ev(EV_TX, 2'd0);   ev(SIG_EOSAR, ST_CONV);
        bus.eoramp_i = 1'b1;
        expect_ev(EV_DONE, 2'd0); ev(SIG_EOT, ST_TX);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (bus.done_o && lat == 0) lat = i;
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL ramp_done_latency: got %0d required 2 negedges after eot edge", lat);
        end
        checks++;
        if (bus.sample_cnt_o !== 16'd2 || bus.ch_sel_o !== 2'd0 || bus.busy_o !== 1'b0 || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL ramp_end: cnt=%0d ch=%0d busy=%b err=%b required 2/0/0/0",
                     bus.sample_cnt_o, bus.ch_sel_o, bus.busy_o, bus.err_o);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL ramp_pending: got %0d pending strobes required 0", exp_q.size());
        end
        bus.eoramp_i = 1'b0;
    endtask

    task automatic test_scan();
        wait_state(ST_IDLE, "scan_idle");
        bus.eoramp_i = 1'b1;
        expect_ev(EV_RAMP, 2'd0); send_cmd(8'h02);
        expect_ev(EV_SAR, 2'd0);  ev(SIG_TSTART, ST_SYNC);
        for (int c = 0; c < 4; c++) begin
            expect_ev(EV_TX, 2'(c)); ev(SIG_EOSAR, ST_CONV);
            checks++;
            if (bus.ch_sel_o !== 2'(c)) begin
                errors++;
                $display("FAIL scan_ch: got %0d required %0d", bus.ch_sel_o, c);
            end
            if (c < 3) expect_ev(EV_SAR, 2'd0);
            else       expect_ev(EV_DONE, 2'd0);
            ev(SIG_EOT, ST_TX);
        end
        wait_state(ST_IDLE, "scan_end");
        checks++;
        if (bus.sample_cnt_o !== 16'd1 || bus.ch_sel_o !== 2'd0 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scan_end: cnt=%0d ch=%0d pending=%0d required 1/0/0",
                     bus.sample_cnt_o, bus.ch_sel_o, exp_q.size());
        end
        bus.eoramp_i = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        wait_state(ST_IDLE, "tmo_idle");
        expect_ev(EV_RAMP, 2'd0); send_cmd(8'h02);
        expect_ev(EV_SAR, 2'd0);  ev(SIG_TSTART, ST_SYNC);
        n = 0;
        while (dbg_state !== ST_IDLE && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL tmo_latency: got %0d required 15 cycles after CONV entry", n);
        end
        checks++;
        if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_err: err=%b busy=%b required 1/0", bus.err_o, bus.busy_o);
        end
        expect_ev(EV_RAMP, 2'd0); send_cmd(8'h01);
        wait_state(ST_SYNC, "tmo_restart");
        checks++;
        if (bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_err_clear: err=%b required 0", bus.err_o);
        end
        send_cmd(8'h03);
        checks++;
        if (dbg_state !== ST_IDLE || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_sync: state=%0d err=%b required 0/0", dbg_state, bus.err_o);
        end
    endtask

    task automatic test_abort();
        wait_state(ST_IDLE, "abort_idle");
        bus.eoramp_i = 1'b0;
        expect_ev(EV_RAMP, 2'd0); send_cmd(8'h02);
        expect_ev(EV_SAR, 2'd0);  ev(SIG_TSTART, ST_SYNC);
        for (int c = 0; c < 4; c++) begin
            expect_ev(EV_TX, 2'(c)); ev(SIG_EOSAR, ST_CONV);
            if (c < 3) expect_ev(EV_SAR, 2'd0);
            ev(SIG_EOT, ST_TX);
        end
        expect_ev(EV_SAR, 2'd0);  ev(SIG_TSAMPLE, ST_NEXT);
        expect_ev(EV_TX, 2'd0);   ev(SIG_EOSAR, ST_CONV);
        expect_ev(EV_SAR, 2'd0);  ev(SIG_EOT, ST_TX);
        wait_state(ST_CONV, "abort_conv");
        @(posedge clk); #1;
        bus.cmd_i = 8'h03; bus.cmd_valid_i = 1'b1; bus.eosar_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.start_tx_o !== 1'b0 || bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse: tx=%b done=%b required 0/0", bus.start_tx_o, bus.done_o);
        end
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0; bus.eosar_i = 1'b0;
        checks++;
        if (dbg_state !== ST_IDLE || bus.ch_sel_o !== 2'd1 || bus.sample_cnt_o !== 16'd1 || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold: state=%0d ch=%0d cnt=%0d err=%b required 0/1/1/0",
                     dbg_state, bus.ch_sel_o, bus.sample_cnt_o, bus.err_o);
        end
    endtask

    task automatic test_unknown();
        logic [7:0] codes[2];
        int         cnt;
        codes[0] = 8'h7F;
        codes[1] = 8'h03;
        for (int k = 0; k < 2; k++) begin
            wait_state(ST_IDLE, "unk_idle");
            cnt = 0;
            @(posedge clk); #1;
            bus.cmd_i = codes[k]; bus.cmd_valid_i = 1'b1;
            @(negedge clk);
            if (bus.busy_o) cnt++;
            @(posedge clk); #1;
            bus.cmd_valid_i = 1'b0;
            repeat (5) begin
                @(negedge clk);
                if (bus.busy_o) cnt++;
            end
            checks++;
            if (cnt !== 1 || dbg_state !== ST_IDLE) begin
                errors++;
                $display("FAIL unknown_cmd_%h: busy cycles=%0d state=%0d required 1/0", codes[k], cnt, dbg_state);
            end
        end
    endtask

    task automatic test_reset_mid();
        wait_state(ST_IDLE, "rmid_idle");
        bus.eoramp_i = 1'b0;
        expect_ev(EV_RAMP, 2'd0); send_cmd(8'h02);
        expect_ev(EV_SAR, 2'd0);  ev(SIG_TSTART, ST_SYNC);
        for (int c = 0; c < 2; c++) begin
            expect_ev(EV_TX, 2'(c)); ev(SIG_EOSAR, ST_CONV);
            expect_ev(EV_SAR, 2'd0); ev(SIG_EOT, ST_TX);
        end
        expect_ev(EV_TX, 2'd2); ev(SIG_EOSAR, ST_CONV);
        bus.eot_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy_o, bus.done_o, bus.err_o, bus.start_tx_o, bus.start_ramp_o,
             bus.start_sar_o, bus.ch_sel_o, bus.sample_cnt_o} !== 24'd0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_mid: state=%0d busy=%b sar=%b ch=%0d required all 0",
                     dbg_state, bus.busy_o, bus.start_sar_o, bus.ch_sel_o);
        end
        bus.eot_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_mid_pending: got %0d required 0", exp_q.size());
        end
        test_ramp();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.cmd_i = '0; bus.cmd_valid_i = 1'b0; bus.eot_i = 1'b0; bus.eoramp_i = 1'b0;
        bus.eosar_i = 1'b0; bus.tick_start_i = 1'b0; bus.tick_sample_i = 1'b0;
        test_reset();
        test_ramp();
        test_scan();
        test_timeout();
        test_abort();
        test_unknown();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL final_pending: got %0d required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
